// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - instruction memory and decode-side bus of the fetch queue
interface inst_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   iad;
    logic [31:0]   idt;
    logic          acki_n;
    logic          deq_ready;
    logic          deq_valid;
    logic [31:0]   deq_pc;
    logic [31:0]   deq_pc4;
    logic [31:0]   deq_ir;
    logic [CW-1:0] count;

    modport slave (
        output iad,
        input  idt,
        input  acki_n,
        input  deq_ready,
        output deq_valid,
        output deq_pc,
        output deq_pc4,
        output deq_ir,
        output count
    );

    modport master (
        input  iad,
        output idt,
        output acki_n,
        output deq_ready,
        input  deq_valid,
        input  deq_pc,
        input  deq_pc4,
        input  deq_ir,
        input  count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction prefetch queue owning the fetch PC
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    inst_fetch_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_entry_pc  [DEPTH];
    logic [31:0]   r_entry_pc4 [DEPTH];
    logic [31:0]   r_entry_ir  [DEPTH];

    logic w_push;
    logic w_pop;
    logic w_valid;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && bus.deq_ready && !redirect;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign w_push  = !bus.acki_n && !redirect && ((r_count < CNT_MAX) || w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_wr_ptr   <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entries are cleared on reset so the stale head reads as zero until first use.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry_pc[i]  <= '0;
                r_entry_pc4[i] <= '0;
                r_entry_ir[i]  <= '0;
            end
        end else if (w_push) begin
            r_entry_pc[r_wr_ptr]  <= r_fetch_pc;
            r_entry_pc4[r_wr_ptr] <= r_fetch_pc + 32'd4;
            r_entry_ir[r_wr_ptr]  <= bus.idt;
        end
    end

    assign bus.iad       = r_fetch_pc;
    assign bus.count     = r_count;
    assign bus.deq_valid = w_valid;
    assign bus.deq_pc    = r_entry_pc[r_rd_ptr];
    assign bus.deq_pc4   = r_entry_pc4[r_rd_ptr];
    assign bus.deq_ir    = w_valid ? r_entry_ir[r_rd_ptr] : NOP_INST;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed bench for inst_fetch_queue
module tb_inst_fetch_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    int          n_cmp = 0;
    int          n_err = 0;

    inst_fetch_queue_if #(.DEPTH(4)) bus ();

    inst_fetch_queue #(
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000),
        .NOP_INST(32'h0000_0013)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    // Memory image: word at byte address A holds A/4.
    assign bus.idt = {2'b00, bus.iad[31:2]};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        bus.acki_n = 1'b1; bus.deq_ready = 1'b0;
        step();
        step();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid", 32'(bus.deq_valid), 32'd0);
        chk("rst_ir", bus.deq_ir, 32'h13);
        chk("rst_pc", bus.deq_pc, 32'h0);
        chk("rst_pc4", bus.deq_pc4, 32'h0);
        chk("rst_iad", bus.iad, 32'h0);

        // fill to full
        rst_n = 1'b1; bus.acki_n = 1'b0;
        step();
        chk("fill1_count", 32'(bus.count), 32'd1);
        chk("fill1_iad", bus.iad, 32'h4);
        step(); step(); step();
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_iad", bus.iad, 32'h10);
        step();
        chk("full_hold_count", 32'(bus.count), 32'd4);
        chk("full_hold_iad", bus.iad, 32'h10);
        chk("full_pc", bus.deq_pc, 32'h0);
        chk("full_ir", bus.deq_ir, 32'h0);

        // full with simultaneous push and pop
        bus.deq_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("stream_count", 32'(bus.count), 32'd4);
            chk("stream_pc", bus.deq_pc, 32'(4 * k));
            chk("stream_pc4", bus.deq_pc4, 32'(4 * k + 4));
            chk("stream_ir", bus.deq_ir, 32'(k));
            chk("stream_iad", bus.iad, 32'(16 + 4 * k));
        end

        // drain one to reach count=3, then redirect
        bus.acki_n = 1'b1;
        step();
        chk("pre_redir_count", 32'(bus.count), 32'd3);
        chk("pre_redir_pc", bus.deq_pc, 32'h1C);
        redirect = 1'b1; redirect_pc = 32'h0000_0103; bus.acki_n = 1'b0;
        step();
        chk("redir_count", 32'(bus.count), 32'd0);
        chk("redir_valid", 32'(bus.deq_valid), 32'd0);
        chk("redir_ir", bus.deq_ir, 32'h13);
        chk("redir_iad", bus.iad, 32'h100);
        redirect = 1'b0; bus.deq_ready = 1'b0;
        step();
        chk("after_redir_count", 32'(bus.count), 32'd1);
        chk("after_redir_pc", bus.deq_pc, 32'h100);
        chk("after_redir_ir", bus.deq_ir, 32'h40);
        chk("after_redir_iad", bus.iad, 32'h104);
        step();
        chk("two_count", 32'(bus.count), 32'd2);

        // memory wait while ID drains the buffer
        bus.acki_n = 1'b1; bus.deq_ready = 1'b1;
        step();
        chk("wait1_count", 32'(bus.count), 32'd1);
        chk("wait1_pc", bus.deq_pc, 32'h104);
        step();
        chk("wait2_valid", 32'(bus.deq_valid), 32'd0);
        chk("wait2_ir", bus.deq_ir, 32'h13);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("wait_iad", bus.iad, 32'h108);
            chk("wait_count", 32'(bus.count), 32'd0);
        end
        bus.acki_n = 1'b0; bus.deq_ready = 1'b0;
        step();
        chk("resume_count", 32'(bus.count), 32'd1);
        chk("resume_pc", bus.deq_pc, 32'h108);
        chk("resume_ir", bus.deq_ir, 32'h42);
        chk("resume_iad", bus.iad, 32'h10C);
        step();
        chk("pre_rst_count", 32'(bus.count), 32'd2);

        // reset wins over a concurrent redirect
        rst_n = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_iad", bus.iad, 32'h0);
        chk("midrst_valid", 32'(bus.deq_valid), 32'd0);
        chk("midrst_pc", bus.deq_pc, 32'h0);

        // address wrap at the top of memory
        rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        chk("wrap_iad0", bus.iad, 32'hFFFF_FFF8);
        redirect = 1'b0; bus.acki_n = 1'b0; bus.deq_ready = 1'b0;
        step();
        chk("wrap1_pc", bus.deq_pc, 32'hFFFF_FFF8);
        chk("wrap1_pc4", bus.deq_pc4, 32'hFFFF_FFFC);
        chk("wrap1_iad", bus.iad, 32'hFFFF_FFFC);
        step();
        chk("wrap2_iad", bus.iad, 32'h0);
        step();
        chk("wrap3_count", 32'(bus.count), 32'd3);
        chk("wrap3_iad", bus.iad, 32'h4);
        bus.acki_n = 1'b1; bus.deq_ready = 1'b1;
        step();
        chk("wrap_pop1_pc", bus.deq_pc, 32'hFFFF_FFFC);
        chk("wrap_pop1_pc4", bus.deq_pc4, 32'h0);
        chk("wrap_pop1_ir", bus.deq_ir, 32'h3FFF_FFFF);
        step();
        chk("wrap_pop2_pc", bus.deq_pc, 32'h0);
        chk("wrap_pop2_pc4", bus.deq_pc4, 32'h4);
        chk("wrap_pop2_ir", bus.deq_ir, 32'h0);
        chk("wrap_pop2_count", 32'(bus.count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
